frame_serializer: RTL and testbench
===================================

# frame_serializer

Converts each 128-sample Hamming-windowed frame, presented in parallel with a one-cycle valid pulse, into a sample-per-beat stream with a valid/ready handshake for the downstream FFT/spectral stage. It sits directly after the `hamming` stage in the keyword-spotter top level. It latches a complete frame so the window stage is free to proceed. It marks frame boundaries and counts frames dropped because the stream was still busy.

## Interface
- `DATA_W`, default 12: sample width, two's complement.
- `N`, default 128: samples per frame; must be a power of two and at least 2.
- `clk`  in  1: system clock, single clock domain.
- `rst`  in  1: reset, synchronous, active-high.
- `in`  in  `DATA_W` x [0:N-1]: windowed frame from `hamming`; element 0 is the oldest sample.
- `in_valid`  in  1: one-cycle pulse; `in` is valid only in that cycle.
- `out_data`  out  `DATA_W`: current stream sample.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts the beat when `out_valid && out_ready`.
- `out_index`  out  log2(`N`): index of the current sample within its frame.
- `out_first`  out  1: high with the sample at index 0.
- `out_last`  out  1: high with the sample at index `N-1`.
- `busy`  out  1: a frame is held and has not been fully streamed.
- `drop_count`  out  8: number of frames dropped; saturates at 255.

## Operation
- Storage:
  - One frame buffer of `N` x `DATA_W` bits, loaded in a single cycle from `in`.
  - The buffer is not cleared by reset; its contents are don't-care after reset.
- States:
  - IDLE: no frame held.
  - STREAM: frame held, beats in progress.
- IDLE to STREAM: on `in_valid`, load the buffer, set the index to 0, set `drop_count` unchanged.
- In STREAM, a beat is accepted when `out_valid && out_ready`.
  - An accepted beat with index below `N-1` increments the index.
  - An accepted beat with index `N-1` (the last beat) ends the frame.
  - After the last beat, the block goes to IDLE, unless `in_valid` is high in that same cycle. In that case it loads the new frame, sets the index to 0 and stays in STREAM. No drop, no bubble.
- Drops:
  - `in_valid` in STREAM in any cycle other than the last-beat cycle is dropped.
  - A dropped frame leaves the buffer and index untouched and increments `drop_count` by 1. The count saturates at 255; further drops leave it at 255.
- Output signals:
  - `out_valid` equals (state == STREAM).
  - `out_data` equals `buf[index]` when `out_valid` is high, and 0 otherwise.
  - `out_index` equals the index register, which reads 0 in IDLE.
  - `out_first` equals `out_valid && index == 0`.
  - `out_last` equals `out_valid && index == N-1`.
  - `busy` equals `out_valid`.
- Backpressure: while `out_valid && !out_ready`, the following stay stable until acceptance: `out_data`, `out_index`, `out_first`, `out_last`.
- Arithmetic: no sample arithmetic. Samples pass bit-exact.
- Index width: log2(`N`) bits. It never wraps on its own; it is reset to 0 at every frame load.

## Timing
- Every output is a function of registered state only. There is no combinational path from `in`, `in_valid` or `out_ready` to any output.
- Reset values, one cycle after `rst` is sampled high:
  - state IDLE, index 0, `drop_count` 0.
  - `out_valid` 0, `out_data` 0, `out_index` 0, `out_first` 0, `out_last` 0, `busy` 0.
- Reset mid-frame: the partial frame is abandoned with no further beats. `drop_count` is cleared. `in_valid` in the reset cycle is ignored.
- Latency: `in_valid` at cycle t gives `out_valid=1`, `out_first=1`, `out_data=in[0]` at t+1.
- Throughput:
  - With `out_ready` held high, one sample per cycle.
  - The frame occupies cycles t+1 to t+N.
  - Back-to-back frames are gap-free only when the next `in_valid` coincides with the last beat.
- Minimum frame period without drops: `N` cycles. At 8 kHz sampling the window period is far longer, so drops indicate a stalled consumer.

## Test plan
- Single frame, `out_ready`=1:
  - Stimulus: `in[i]=i` (12-bit), `in_valid` pulse at cycle 10.
  - Response: beats at cycles 11–138 carry data 0..127 and index 0..127.
  - `out_first` is high only at cycle 11; `out_last` only at cycle 138.
  - `out_valid` is 0 at cycle 139.
- Backpressure:
  - Stimulus: toggle `out_ready` on a 1-on/2-off pattern.
  - Response: all 128 samples arrive in order with none repeated or skipped.
  - Data and index are held stable during every stall.
  - Negative samples (0x800, 0xFFF) pass bit-exact.
- Drop and saturation:
  - Stimulus: `in_valid` at beat index 5 of a frame.
  - Response: `drop_count` becomes 1 and the stream continues with the original data.
  - Stimulus: 300 further mid-frame pulses.
  - Response: `drop_count` reads 255.
- Coincident load:
  - Stimulus: `in_valid` in the same cycle as the last-beat acceptance.
  - Response: the next cycle shows `out_first=1` with new-frame sample 0, and `drop_count` is unchanged.
  - Stimulus: the same pulse one cycle earlier.
  - Response: the frame is dropped and the block goes to IDLE after the last beat.
- Reset mid-frame:
  - Stimulus: assert `rst` at beat index 60 with `drop_count`=3.
  - Response: the next cycle has all outputs at reset values and `drop_count`=0.
  - A following `in_valid` streams a full new frame from index 0.
- Parameter sweep:
  - Stimulus: `N`=4, `DATA_W`=16; repeat the single-frame and coincident-load cases.
  - Response: 4 beats per frame, with `out_last` at index 3.

Source files
------------

// File: rtl/frame_serializer.sv
// frame_serializer
//   Latches one N-sample windowed frame in a single cycle and replays it as a
//   sample-per-beat stream, so the upstream window stage never waits on the
//   downstream spectral stage. Frames that arrive while a stream is still in
//   progress are counted as drops. A frame arriving exactly on the last-beat
//   acceptance is loaded without a gap.
//
// Ports
//   clk, rst    : single clock, synchronous active-high reset
//   in          : N x DATA_W frame, element 0 is the oldest sample
//   in_valid    : one-cycle pulse qualifying `in`
//   out_data    : current sample (0 when no frame is held)
//   out_valid   : stream beat available
//   out_ready   : consumer accepts the beat on out_valid && out_ready
//   out_index   : position of the current sample within its frame
//   out_first   : current beat is sample 0
//   out_last    : current beat is sample N-1
//   busy        : a frame is held and not yet fully streamed
//   drop_count  : saturating count of frames dropped while busy
//   state_dbg   : raw FSM state (0 = IDLE, 1 = STREAM)
//
// Handshake: a beat transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, and out_data,
// out_index, out_first and out_last hold their values, until that beat
// transfers. out_valid never depends on out_ready.

module frame_serializer #(
  parameter int DATA_W = 12,
  parameter int N      = 128,
  localparam int IW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in [0:N-1],
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW-1:0]     out_index,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        drop_count,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] frame_buf [0:N-1];
  logic [IW-1:0]     index;
  logic [IW-1:0]     index_nxt;
  logic              accept;
  logic              last_acc;
  logic              load;
  logic              drop;

  always_comb begin
    accept    = out_valid && out_ready;
    last_acc  = accept && out_last;
    // A new frame is taken when nothing is held, or when the held frame
    // finishes on this very edge (gap-free back-to-back frames).
    load      = in_valid && (!out_valid || last_acc);
    drop      = in_valid && out_valid && !last_acc;
    index_nxt = index + IW'(1);
  end

  // Frame storage carries no reset; its contents only matter once a load
  // has put the FSM into STREAM.
  always_ff @(posedge clk) begin
    if (load && !rst) begin
      for (int i = 0; i < N; i++) begin
        frame_buf[i] <= in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      drop_count <= '0;
      out_data   <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end

      if (load) begin
        // Sample 0 comes straight from the input bus because the buffer
        // is being written on this same edge.
        state     <= STREAM;
        index     <= '0;
        out_data  <= in[0];
        out_first <= 1'b1;
        out_last  <= 1'b0;
      end else if (last_acc) begin
        state     <= IDLE;
        index     <= '0;
        out_data  <= '0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end else if (accept) begin
        index     <= index_nxt;
        out_data  <= frame_buf[index_nxt];
        out_first <= 1'b0;
        out_last  <= (index_nxt == IW'(N - 1));
      end
    end
  end

  assign out_valid = (state == STREAM);
  assign busy      = out_valid;
  assign out_index = index;
  assign state_dbg = state;

endmodule

// File: tb/tb_frame_serializer.sv
module tb_frame_serializer;

  localparam int NA = 128;
  localparam int WA = 12;
  localparam int NB = 4;
  localparam int WB = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic [WA-1:0] in_a [0:NA-1];
  logic          in_valid_a = 1'b0;
  logic [WA-1:0] out_data_a;
  logic          out_valid_a;
  logic          out_ready_a = 1'b1;
  logic [6:0]    out_index_a;
  logic          out_first_a, out_last_a, busy_a, state_dbg_a;
  logic [7:0]    drop_count_a;

  // DUT B: N=4, DATA_W=16
  logic [WB-1:0] in_b [0:NB-1];
  logic          in_valid_b = 1'b0;
  logic [WB-1:0] out_data_b;
  logic          out_valid_b;
  logic          out_ready_b = 1'b1;
  logic [1:0]    out_index_b;
  logic          out_first_b, out_last_b, busy_b, state_dbg_b;
  logic [7:0]    drop_count_b;

  frame_serializer #(.DATA_W(WA), .N(NA)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .in_valid(in_valid_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_index(out_index_a), .out_first(out_first_a), .out_last(out_last_a),
    .busy(busy_a), .drop_count(drop_count_a), .state_dbg(state_dbg_a)
  );

  frame_serializer #(.DATA_W(WB), .N(NB)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_index(out_index_b), .out_first(out_first_b), .out_last(out_last_b),
    .busy(busy_b), .drop_count(drop_count_b), .state_dbg(state_dbg_b)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [WA+7+1:0] exp_a [$];   // {data, index, first, last}
  logic [WB+2+1:0] exp_b [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // driver tasks (called at #1 after a rising edge)
  task automatic push_a();
    for (int i = 0; i < NA; i++)
      exp_a.push_back({in_a[i], 7'(i), (i == 0), (i == NA - 1)});
  endtask

  task automatic push_b();
    for (int i = 0; i < NB; i++)
      exp_b.push_back({in_b[i], 2'(i), (i == 0), (i == NB - 1)});
  endtask

  task automatic pulse_a(input bit expect_load);
    in_valid_a = 1'b1;
    if (expect_load) push_a();
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic pulse_b(input bit expect_load);
    in_valid_b = 1'b1;
    if (expect_load) push_b();
    @(posedge clk); #1;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_idx_a(input int k);
    int n = 0;
    while (!(out_valid_a && out_index_a == 7'(k)) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL wait_idx_a timeout got=%0d exp=%0d", out_index_a, k);
    end
  endtask

  task automatic wait_idx_b(input int k);
    int n = 0;
    while (!(out_valid_b && out_index_b == 2'(k)) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_idx_b timeout got=%0d exp=%0d", out_index_b, k);
    end
  endtask

  task automatic wait_empty_a();
    int n = 0;
    while (exp_a.size() != 0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_a timeout got=%0d exp=0", exp_a.size());
    end
  endtask

  task automatic wait_empty_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_b timeout got=%0d exp=0", exp_b.size());
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_valid_a"}, out_valid_a, 0);
    chk({tag, "_data_a"},  out_data_a,  0);
    chk({tag, "_index_a"}, out_index_a, 0);
    chk({tag, "_first_a"}, out_first_a, 0);
    chk({tag, "_last_a"},  out_last_a,  0);
    chk({tag, "_busy_a"},  busy_a,      0);
    chk({tag, "_drop_a"},  drop_count_a, 0);
  endtask

  // monitors: pop on every accepted beat, verify hold during stalls
  logic [WA+7+1:0] got_a, hold_a;
  logic [WB+2+1:0] got_b, hold_b;
  bit stall_a = 0;
  bit stall_b = 0;

  always @(negedge clk) begin
    got_a = {out_data_a, out_index_a, out_first_a, out_last_a};
    if (rst) begin
      stall_a = 0;
    end else begin
      if (stall_a) chk("hold_a", got_a, hold_a);
      if (out_valid_a && out_ready_a) begin
        stall_a = 0;
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_a unexpected got=%0h exp=none", got_a);
        end else begin
          chk("beat_a", got_a, exp_a.pop_front());
        end
      end else if (out_valid_a) begin
        stall_a = 1;
        hold_a  = got_a;
      end else begin
        stall_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    got_b = {out_data_b, out_index_b, out_first_b, out_last_b};
    if (rst) begin
      stall_b = 0;
    end else begin
      if (stall_b) chk("hold_b", got_b, hold_b);
      if (out_valid_b && out_ready_b) begin
        stall_b = 0;
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_b unexpected got=%0h exp=none", got_b);
        end else begin
          chk("beat_b", got_b, exp_b.pop_front());
        end
      end else if (out_valid_b) begin
        stall_b = 1;
        hold_b  = got_b;
      end else begin
        stall_b = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NA; i++) in_a[i] = '0;
    for (int i = 0; i < NB; i++) in_b[i] = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("rst");
    chk("rst_valid_b", out_valid_b, 0);
    chk("rst_drop_b", drop_count_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single frame, ready held high
    for (int i = 0; i < NA; i++) in_a[i] = 12'(i);
    pulse_a(1);
    chk("t1_first", out_first_a, 1);
    chk("t1_data0", out_data_a, 0);
    chk("t1_busy", busy_a, 1);
    chk("t1_state", state_dbg_a, 1);
    repeat (NA - 1) @(posedge clk);
    #1;
    chk("t1_last", out_last_a, 1);
    chk("t1_lastidx", out_index_a, 127);
    @(posedge clk); #1;
    chk("t1_idle_valid", out_valid_a, 0);
    chk("t1_idle_data", out_data_a, 0);

    // backpressure 1-on / 2-off, with negative samples
    in_a[0] = 12'h800;
    in_a[1] = 12'hFFF;
    for (int i = 2; i < NA; i++) in_a[i] = 12'(i * 29 + 5);
    pulse_a(1);
    for (int c = 0; c < 600 && exp_a.size() != 0; c++) begin
      out_ready_a = (c % 3 == 0);
      @(posedge clk); #1;
    end
    out_ready_a = 1'b1;
    chk("bp_drained", exp_a.size(), 0);
    chk("bp_idle", out_valid_a, 0);

    // coincident load: no drop, no bubble
    for (int i = 0; i < NA; i++) in_a[i] = 12'(i + 1000);
    pulse_a(1);
    wait_idx_a(NA - 1);
    for (int i = 0; i < NA; i++) in_a[i] = 12'(2000 - i);
    pulse_a(1);
    chk("co_first", out_first_a, 1);
    chk("co_data0", out_data_a, 2000);
    chk("co_index", out_index_a, 0);
    chk("co_drop", drop_count_a, 0);
    // one cycle early: dropped, then idle after the last beat
    wait_idx_a(NA - 2);
    for (int i = 0; i < NA; i++) in_a[i] = 12'hABC;
    pulse_a(0);
    chk("early_drop", drop_count_a, 1);
    wait_empty_a();
    chk("early_idle", out_valid_a, 0);

    // drop mid-frame and saturation
    for (int i = 0; i < NA; i++) in_a[i] = 12'(i * 3 + 100);
    pulse_a(1);
    wait_idx_a(5);
    pulse_a(0);
    chk("drop_one", drop_count_a, 2);
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    chk("drop_sat", drop_count_a, 255);
    chk("drop_still_streaming", out_valid_a, 1);
    pulse_a(0);
    chk("drop_sat_hold", drop_count_a, 255);
    out_ready_a = 1'b1;
    wait_empty_a();

    // reset mid-frame
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_drop", drop_count_a, 0);
    for (int i = 0; i < NA; i++) in_a[i] = 12'(i ^ 12'h5A5);
    pulse_a(1);
    wait_idx_a(2);
    in_valid_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    chk("rst_pre_drop", drop_count_a, 3);
    wait_idx_a(60);
    rst = 1'b1;
    in_valid_a = 1'b1;
    exp_a.delete();
    @(posedge clk); #1;
    chk_reset_a("midrst");
    rst = 1'b0;
    in_valid_a = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ignored", out_valid_a, 0);
    for (int i = 0; i < NA; i++) in_a[i] = 12'(4095 - i);
    pulse_a(1);
    chk("midrst_first", out_first_a, 1);
    wait_empty_a();
    chk("midrst_idle", out_valid_a, 0);

    // N=4, DATA_W=16: single frame
    in_b[0] = 16'h8000; in_b[1] = 16'h1234; in_b[2] = 16'hFFFF; in_b[3] = 16'h7FFF;
    pulse_b(1);
    chk("b_first", out_first_b, 1);
    chk("b_data0", out_data_b, 16'h8000);
    repeat (NB - 1) @(posedge clk);
    #1;
    chk("b_last", out_last_b, 1);
    chk("b_lastidx", out_index_b, 3);
    @(posedge clk); #1;
    chk("b_idle", out_valid_b, 0);

    // N=4: coincident load then early pulse
    in_b[0] = 16'h0001; in_b[1] = 16'h0002; in_b[2] = 16'h0003; in_b[3] = 16'h0004;
    pulse_b(1);
    wait_idx_b(NB - 1);
    in_b[0] = 16'hF00D; in_b[1] = 16'hBEEF; in_b[2] = 16'h0000; in_b[3] = 16'hC001;
    pulse_b(1);
    chk("b_co_first", out_first_b, 1);
    chk("b_co_data0", out_data_b, 16'hF00D);
    chk("b_co_drop", drop_count_b, 0);
    wait_idx_b(NB - 2);
    in_b[0] = 16'h1111;
    pulse_b(0);
    chk("b_early_drop", drop_count_b, 1);
    wait_empty_b();
    chk("b_early_idle", out_valid_b, 0);

    chk("end_queue_a", exp_a.size(), 0);
    chk("end_queue_b", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
